fp_normalize_stage: RTL and testbench
=====================================

Name: fp_normalize_stage

Overview:
- Sequential normalisation stage directly downstream of the 24-bit floating-point adder datapath.
- Consumes the raw adder result: sign, larger exponent, 24-bit mantissa sum and adder carry-out.
- Produces a normalised IEEE-754 single-precision word.
- Handles carry renormalisation (right shift 1), leading-zero cancellation after subtraction (left shift, one bit per cycle), zero, overflow to infinity and denormal results. Uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 24, mantissa width including hidden bit; output fraction is MANT_W-1 bits.
- SHCNT_W, 5, width of the shift counter; must hold MANT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  raw result present.
- in_ready  output  1  stage can accept; equals (state==IDLE) && !rst.
- in_sign  input  1  result sign.
- in_exp  input  EXP_W  max(EA,EB) from adder.
- in_mant  input  MANT_W  adder sum; bit MANT_W-1 is the hidden-bit position.
- in_cout  input  1  adder carry-out (sum bit MANT_W).
- out_valid  output  1  normalised result held.
- out_ready  input  1  consumer accepts.
- out  output  1+EXP_W+MANT_W-1  {sign, exp, fraction}.
- out_zero  output  1  result is zero.
- out_ovf  output  1  exponent overflow; out is infinity.
- out_denorm  output  1  result is denormal (exp field 0, fraction non-zero).
- out_shifts  output  SHCNT_W  left shifts performed for this result.

Behaviour:
- Reset (async, any state): FSM→IDLE. All registers and outputs are 0. Any in-flight operation is discarded. in_ready rises on the first clock after rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, in_valid=1 (handshake), registers capture the operand; next state is selected by priority:
  - in_cout=1: exp+1 and mant={1,in_mant[MANT_W-1:1]} (truncate LSB). If in_exp+1 == all-ones → DONE with out = {sign, all-ones, 0}, out_ovf=1. Otherwise → SHIFT.
  - in_mant==0: → DONE, out = all-zeros (+0), out_zero=1, sign dropped.
  - in_exp==0: → DONE unchanged as denormal, out_denorm=1.
  - otherwise → SHIFT.
- SHIFT, evaluated each cycle:
  - mant[MSB]=1 → DONE.
  - exp==1 and mant[MSB]=0 → exp=0, no shift, out_denorm=1, → DONE.
  - otherwise mant<<=1, exp-=1, shift counter +1, stay in SHIFT.
  - The shift count never exceeds MANT_W-1, because non-zero mantissa is guaranteed.
- DONE: out_valid=1. out, flags and out_shifts are stable and registered. On out_ready=1 → IDLE, and out_valid drops next cycle. No new operand is accepted in the DONE→IDLE cycle.
- Latency from the accepting edge to out_valid: zero/overflow/input-denormal take 1 cycle; normalised or carry input takes 2 cycles; k leading zeros take 2+k cycles.
- Throughput: one result in flight at a time. in_ready=0 in SHIFT and DONE.
- Output fraction is mant[MANT_W-2:0]. The hidden bit is not emitted.
- out_shifts counts left shifts only; it is 0 for the carry path.
- Output stability: while out_valid=1 and out_ready=0, all outputs are held indefinitely.
- The input fields are sampled only on the accepting edge. Later changes to in_* are ignored.

Test Plan:
- Already normalised: in_exp=8'h80, in_mant=24'h800000, cout=0, sign=0 → out=32'h40000000, out_shifts=0, out_valid after 2 edges.
- Carry path (1.0+1.0): in_exp=8'h7F, in_mant=24'h000000, cout=1 → out=32'h40000000, all flags 0, out_valid after 2 edges.
- Cancellation: in_exp=8'h85, in_mant=24'h000100, sign=1 → out=32'hBB000000, out_shifts=15, out_valid after 17 edges.
- Corner cases:
  - in_mant=0, sign=1 → out=32'h00000000, out_zero=1 after 1 edge.
  - in_exp=8'hFE, cout=1 → out=32'h7F800000, out_ovf=1 after 1 edge.
  - in_exp=8'h03, in_mant=24'h100000 → out=32'h00400000, out_denorm=1, out_shifts=2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out constant, in_ready=0, in_valid pulses ignored. Then out_ready=1 → IDLE, and the next operand is accepted no earlier than 1 cycle later.
- Reset mid-SHIFT: assert rst during the third shift of the cancellation case → outputs 0 immediately, state IDLE. After release, a fresh operand produces a correct result with out_shifts counted from 0.

Source files
------------

// File: rtl/fp_normalize_stage.sv
// Normalises the raw 24-bit FP adder result (sign, max exponent, mantissa sum, carry-out) into an IEEE-754 single word.
// Latency: 1 cycle for zero/overflow/input-denormal, 2 for carry or already-normalised input, 2+k for k leading zeros.
// Backpressure: one result in flight; in_ready is low in SHIFT and DONE, and DONE holds every output until out_ready.
//
// Ports:
//   clk, rst                     - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready            - input handshake; operand fields are sampled only on the accepting edge
//   in_sign, in_exp, in_mant     - raw adder result; in_mant[MANT_W-1] is the hidden-bit position
//   in_cout                      - adder carry-out (sum bit MANT_W)
//   out_valid/out_ready          - output handshake
//   out                          - {sign, exponent, fraction}; hidden bit not emitted
//   out_zero/out_ovf/out_denorm  - result class flags
//   out_shifts                   - number of left shifts performed for this result
module fp_normalize_stage #(
    parameter int EXP_W   = 8,
    parameter int MANT_W  = 24,
    parameter int SHCNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic                    in_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] out,
    output logic                    out_zero,
    output logic                    out_ovf,
    output logic                    out_denorm,
    output logic [SHCNT_W-1:0]      out_shifts
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0]  EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
    localparam logic [MANT_W-2:0] FRAC_ZERO = {(MANT_W-1){1'b0}};

    state_t                    r_state;
    logic                      r_sign;
    logic [EXP_W-1:0]          r_exp;
    logic [MANT_W-1:0]         r_mant;
    logic [SHCNT_W-1:0]        r_shcnt;

    // Output registers: loaded only on entry to DONE so they stay put while
    // the consumer stalls, independent of the working registers above.
    logic                      r_valid;
    logic [EXP_W+MANT_W-1:0]   r_out;
    logic                      r_zero;
    logic                      r_ovf;
    logic                      r_denorm;
    logic [SHCNT_W-1:0]        r_shifts;

    logic [EXP_W-1:0]          w_exp_inc;
    logic                      w_accept;

    assign w_exp_inc = in_exp + EXP_ONE;
    assign w_accept  = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_shcnt  <= '0;
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_denorm <= 1'b0;
            r_shifts <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shcnt <= '0;
                        r_sign  <= in_sign;
                        if (in_cout) begin
                            // Carry renormalisation: the carry becomes the new hidden bit, LSB truncated.
                            if (w_exp_inc == EXP_ONES) begin
                                r_out    <= {in_sign, EXP_ONES, FRAC_ZERO};
                                r_zero   <= 1'b0;
                                r_ovf    <= 1'b1;
                                r_denorm <= 1'b0;
                                r_shifts <= '0;
                                r_valid  <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_exp   <= w_exp_inc;
                                r_mant  <= {1'b1, in_mant[MANT_W-1:1]};
                                r_state <= S_SHIFT;
                            end
                        end else if (in_mant == '0) begin
                            // Exact cancellation gives +0 regardless of the operand sign.
                            r_out    <= '0;
                            r_zero   <= 1'b1;
                            r_ovf    <= 1'b0;
                            r_denorm <= 1'b0;
                            r_shifts <= '0;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (in_exp == EXP_ZERO) begin
                            // Already denormal: no normalisation is possible, pass through.
                            r_out    <= {in_sign, EXP_ZERO, in_mant[MANT_W-2:0]};
                            r_zero   <= 1'b0;
                            r_ovf    <= 1'b0;
                            r_denorm <= 1'b1;
                            r_shifts <= '0;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_exp   <= in_exp;
                            r_mant  <= in_mant;
                            r_state <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    if (r_mant[MANT_W-1]) begin
                        r_out    <= {r_sign, r_exp, r_mant[MANT_W-2:0]};
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_denorm <= 1'b0;
                        r_shifts <= r_shcnt;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_exp == EXP_ONE) begin
                        // Exponent floor reached before the hidden bit: the
                        // denormal encoding uses exponent 0 with the same scale as 1.
                        r_out    <= {r_sign, EXP_ZERO, r_mant[MANT_W-2:0]};
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_denorm <= 1'b1;
                        r_shifts <= r_shcnt;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_mant  <= {r_mant[MANT_W-2:0], 1'b0};
                        r_exp   <= r_exp - EXP_ONE;
                        r_shcnt <= r_shcnt + SHCNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign out_valid  = r_valid;
    assign out        = r_out;
    assign out_zero   = r_zero;
    assign out_ovf    = r_ovf;
    assign out_denorm = r_denorm;
    assign out_shifts = r_shifts;

endmodule

// File: tb/tb_fp_normalize_stage.sv
module tb_fp_normalize_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_zero;
    logic        out_ovf;
    logic        out_denorm;
    logic [4:0]  out_shifts;

    int checks = 0;
    int errors = 0;

    fp_normalize_stage #(.EXP_W(8), .MANT_W(24), .SHCNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_cout    (in_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_denorm (out_denorm),
        .out_shifts (out_shifts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level view of normalisation. The result keeps the
    // numeric value mant * 2^exp; the leading-zero count is found by scaling
    // and the exponent floor of 1 bounds how far it may be scaled.
    task automatic model(input bit s, input int e, input int m, input bit c,
                         output logic [31:0] o, output bit z, output bit ov,
                         output bit dn, output int sh, output int lat);
        int lz;
        int t;
        int k;
        z = 0; ov = 0; dn = 0; sh = 0;
        if (c) begin
            e = e + 1;
            if (e == 255) begin
                o = {s, 8'hFF, 23'h0};
                ov = 1;
                lat = 1;
            end else begin
                m = (m + (1 << 24)) / 2;
                o = {s, 8'(e), 23'(m % (1 << 23))};
                lat = 2;
            end
        end else if (m == 0) begin
            o = 32'h0;
            z = 1;
            lat = 1;
        end else if (e == 0) begin
            o = {s, 8'h00, 23'(m % (1 << 23))};
            dn = 1;
            lat = 1;
        end else begin
            lz = 0;
            t = m;
            while (t < (1 << 23)) begin
                t = t * 2;
                lz++;
            end
            k = (lz <= e - 1) ? lz : e - 1;
            m = m * (1 << k);
            e = e - k;
            if (lz > k) begin
                dn = 1;
                e = 0;
            end
            o = {s, 8'(e), 23'(m % (1 << 23))};
            sh = k;
            lat = 2 + k;
        end
    endtask

    // Drives one operand (starting at a negedge), scrambles the inputs right
    // after the accepting edge, and returns what the stage produced.
    task automatic do_op(input bit s, input logic [7:0] e, input logic [23:0] m, input bit c,
                         output logic [31:0] o, output logic z, output logic ov,
                         output logic dn, output logic [4:0] sh, output int lat,
                         output bit to);
        int n;
        to = 0;
        lat = 0;
        o = 'x; z = 'x; ov = 'x; dn = 'x; sh = 'x;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1;
            return;
        end
        in_sign = s; in_exp = e; in_mant = m; in_cout = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign = 1'($urandom); in_exp = 8'($urandom);
        in_mant = 24'($urandom); in_cout = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            to = 1;
            return;
        end
        o = out; z = out_zero; ov = out_ovf; dn = out_denorm; sh = out_shifts;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_cout = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 00000000", out); end
        checks++;
        if ({out_zero, out_ovf, out_denorm, out_shifts} !== 8'h0) begin
            errors++; $display("FAIL reset_flags got %b want 0", {out_zero, out_ovf, out_denorm, out_shifts});
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_in_rst got %0b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %0b want 1", in_ready); end
    endtask

    typedef struct {
        string       name;
        bit          s;
        logic [7:0]  e;
        logic [23:0] m;
        bit          c;
        logic [31:0] o;
        logic [2:0]  flags;   // {zero, ovf, denorm}
        logic [4:0]  sh;
        int          lat;
    } vec_t;

    task automatic test_directed;
        vec_t v[6];
        logic [31:0] o;
        logic z, ov, dn;
        logic [4:0] sh;
        int lat;
        bit to;
        v[0] = '{"normalised",   1'b0, 8'h80, 24'h800000, 1'b0, 32'h40000000, 3'b000, 5'd0,  2};
        v[1] = '{"carry",        1'b0, 8'h7F, 24'h000000, 1'b1, 32'h40000000, 3'b000, 5'd0,  2};
        v[2] = '{"cancel",       1'b1, 8'h85, 24'h000100, 1'b0, 32'hBB000000, 3'b000, 5'd15, 17};
        v[3] = '{"zero",         1'b1, 8'h44, 24'h000000, 1'b0, 32'h00000000, 3'b100, 5'd0,  1};
        v[4] = '{"overflow",     1'b0, 8'hFE, 24'h123456, 1'b1, 32'h7F800000, 3'b010, 5'd0,  1};
        v[5] = '{"denorm_shift", 1'b0, 8'h03, 24'h100000, 1'b0, 32'h00400000, 3'b001, 5'd2,  4};
        foreach (v[i]) begin
            do_op(v[i].s, v[i].e, v[i].m, v[i].c, o, z, ov, dn, sh, lat, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL %s_timeout no result within bound", v[i].name);
            end else begin
                if (o !== v[i].o) begin errors++; $display("FAIL %s_out got %h want %h", v[i].name, o, v[i].o); end
                checks++;
                if ({z, ov, dn} !== v[i].flags) begin
                    errors++; $display("FAIL %s_flags got %b want %b", v[i].name, {z, ov, dn}, v[i].flags);
                end
                checks++;
                if (sh !== v[i].sh) begin errors++; $display("FAIL %s_shifts got %0d want %0d", v[i].name, sh, v[i].sh); end
                checks++;
                if (lat != v[i].lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", v[i].name, lat, v[i].lat); end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] o, eo;
        logic z, ov, dn;
        logic [4:0] sh;
        bit ez, eov, edn;
        int esh, elat, lat;
        bit to, s, c;
        logic [7:0] e;
        logic [23:0] m;
        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom);
            c = 1'b0;
            case ($urandom_range(0, 5))
                0: begin c = 1'b1; e = 8'($urandom_range(0, 254)); m = 24'($urandom); end
                1: begin e = 8'($urandom); m = 24'h0; end
                2: begin e = 8'h00; m = 24'($urandom) | 24'h1; end
                default: begin
                    e = 8'($urandom_range(1, 254));
                    m = (24'($urandom) | 24'h800000) >> $urandom_range(0, 23);
                end
            endcase
            model(s, int'(e), int'(m), c, eo, ez, eov, edn, esh, elat);
            do_op(s, e, m, c, o, z, ov, dn, sh, lat, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL rand_timeout op %0d no result within bound", i);
            end else if (o !== eo || {z, ov, dn} !== {ez, eov, edn} || sh !== 5'(esh) || lat != elat) begin
                errors++;
                $display("FAIL rand_result op %0d in s=%0b e=%h m=%h c=%0b got out=%h f=%b sh=%0d lat=%0d want out=%h f=%b sh=%0d lat=%0d",
                         i, s, e, m, c, o, {z, ov, dn}, sh, lat, eo, {ez, eov, edn}, esh, elat);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'h80; in_mant = 24'h800000; in_cout = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin
            errors++; $display("FAIL bp_timeout no result within bound");
            out_ready = 1'b1;
            return;
        end
        held = out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || out_shifts !== 5'd0) begin
                errors++; $display("FAIL bp_hold cycle %0d got out=%h vld=%0b rdy=%0b want out=%h vld=1 rdy=0",
                                   i, out, out_valid, in_ready, held);
            end
            in_valid = 1'b1; in_sign = 1'($urandom); in_exp = 8'($urandom_range(1, 200));
            in_mant = 24'($urandom) | 24'h1; in_cout = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if (out !== 32'h40000000) begin errors++; $display("FAIL bp_value got %h want 40000000", out); end
        // Release the consumer while a new operand is already waiting.
        in_sign = 1'b0; in_exp = 8'h90; in_mant = 24'h400000; in_cout = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_release_rdy got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle got vld=%0b rdy=%0b want vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (out !== 32'h47800000 || out_shifts !== 5'd1 || n != 3) begin
            errors++; $display("FAIL bp_next got out=%h sh=%0d lat=%0d want out=47800000 sh=1 lat=3", out, out_shifts, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] o;
        logic z, ov, dn;
        logic [4:0] sh;
        int lat, n;
        bit to;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_sign = 1'b1; in_exp = 8'h85; in_mant = 24'h000100; in_cout = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b0 || out_shifts !== 5'd0) begin
            errors++; $display("FAIL midrst_outputs got vld=%0b out=%h rdy=%0b sh=%0d want all 0",
                               out_valid, out, in_ready, out_shifts);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b1, 8'h85, 24'h000100, 1'b0, o, z, ov, dn, sh, lat, to);
        checks++;
        if (to || o !== 32'hBB000000 || sh !== 5'd15 || lat != 17 || {z, ov, dn} !== 3'b000) begin
            errors++; $display("FAIL midrst_fresh got to=%0b out=%h sh=%0d lat=%0d f=%b want out=BB000000 sh=15 lat=17 f=000",
                               to, o, sh, lat, {z, ov, dn});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
